// File: rtl/cpu_pkg.sv
// Shared core definitions: opcode encodings, sequencer states, memory geometry defaults.
package cpu_pkg;

  localparam int unsigned IM_AW_DEFAULT = 5;
  localparam int unsigned IW_DEFAULT    = 16;

  typedef enum logic [2:0] {
    OP_STORE  = 3'b000,
    OP_LOAD   = 3'b001,
    OP_ADD    = 3'b010,
    OP_BRANCH = 3'b101,
    OP_HALT   = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALTED
  } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_retire_counter.sv
// Saturating 16-bit retired-instruction counter; only built when FETCH_RETIRE_COUNT_EN is defined.
`ifdef FETCH_RETIRE_COUNT_EN
module retire_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 16'd1;
  end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// PC owner and execution sequencer: free-run / single-step issue, branch, halt, restart.
// Optional retired-instruction counter under macro FETCH_RETIRE_COUNT_EN.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned IM_AW = IM_AW_DEFAULT,
  parameter int unsigned IW    = IW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_run,
  input  logic             step,
  input  logic             branch_eq,
  input  logic [IW-1:0]    instr,
  output logic [IM_AW-1:0] pc,
  output logic             commit,
  output logic             halted,
  output logic             busy,
  output logic [15:0]      retired
);

  seq_state_t       state;
  logic [2:0]       opcode;
  logic             is_halt;
  logic             issue;
  logic [IM_AW-1:0] next_pc;
  logic             unused_instr_bits;

  assign opcode            = instr[IW-1 -: 3];
  assign is_halt           = (opcode == OP_HALT);
  assign issue             = (state == RUN) || ((state == STEP) && step);
  assign commit            = issue && !is_halt;
  assign unused_instr_bits = ^instr[7:0];

  always_comb begin
    next_pc = pc + 1'b1;
    if ((opcode == OP_BRANCH) && branch_eq)
      next_pc = IM_AW'(instr[12:8]);
  end

  // IDLE is only entered from reset, so pc is already 0 there; both share the start path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= '0;
      halted <= 1'b0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
            busy   <= 1'b1;
            state  <= mode_run ? RUN : STEP;
          end
        end
        RUN, STEP: begin
          if (issue && is_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            if (issue)
              pc <= next_pc;
            state <= mode_run ? RUN : STEP;
          end
        end
      endcase
    end
  end

`ifdef FETCH_RETIRE_COUNT_EN
  logic restart;
  assign restart = start && ((state == IDLE) || (state == HALTED));

  retire_counter u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .inc   (commit),
    .count (retired)
  );
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer against a behavioural model of the sequencing rules.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, mode_run, step, branch_eq;
  logic [15:0] instr;
  logic [4:0]  pc;
  logic        commit, halted, busy;
  logic [15:0] retired;
  logic [15:0] imem [32];

  assign instr = imem[pc];

  fetch_sequencer #(.IM_AW(5), .IW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode_run  (mode_run),
    .step      (step),
    .branch_eq (branch_eq),
    .instr     (instr),
    .pc        (pc),
    .commit    (commit),
    .halted    (halted),
    .busy      (busy),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  pc;
    logic        commit;
    logic        halted;
    logic        busy;
    logic [15:0] retired;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;

  // model: phase 0 idle, 1 free run, 2 single step, 3 halted
  int   m_phase, m_pc, m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_on) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pc",      32'(pc),      32'(e.pc));
        chk("commit",  32'(commit),  32'(e.commit));
        chk("halted",  32'(halted),  32'(e.halted));
        chk("busy",    32'(busy),    32'(e.busy));
        chk("retired", 32'(retired), 32'(e.retired));
      end
    end
  end

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 0;
    m_ret   = 0;
  endtask

  // Called at posedge+1: drive inputs, predict this cycle, advance the model, wait one cycle.
  task automatic cycle(input bit s, input bit m, input bit stp, input bit b);
    exp_t        e;
    logic [15:0] w;
    int          op;
    bit          executes;
    start = s; mode_run = m; step = stp; branch_eq = b;
    w  = imem[m_pc[4:0]];
    op = int'(w[15:13]);
    executes = (m_phase == 1) || (m_phase == 2 && stp);
    e.pc     = m_pc[4:0];
    e.commit = executes && (op != 7);
    e.halted = (m_phase == 3);
    e.busy   = (m_phase == 1) || (m_phase == 2);
`ifdef FETCH_RETIRE_COUNT_EN
    e.retired = m_ret[15:0];
`else
    e.retired = 16'd0;
`endif
    sb.push_back(e);
    if (m_phase == 0 || m_phase == 3) begin
      if (s) begin
        m_phase = m ? 1 : 2;
        m_pc    = 0;
        m_ret   = 0;
      end
    end else if (executes && op == 7) begin
      m_phase = 3;
    end else begin
      if (executes) begin
        m_ret = (m_ret < 65535) ? m_ret + 1 : 65535;
        m_pc  = (op == 5 && b) ? int'(w[12:8]) : (m_pc + 1) % 32;
      end
      m_phase = m ? 1 : 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    start = 1'b0; step = 1'b0; mode_run = 1'b1;
    mon_on = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_pc",     32'(pc),      32'd0);
    chk("rst_busy",   32'(busy),    32'd0);
    chk("rst_commit", 32'(commit),  32'd0);
    chk("rst_halted", 32'(halted),  32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    mon_on = 1'b1;
  endtask

  initial begin
    int  guard;
    bit  rm;
    for (int i = 0; i < 32; i++) imem[i] = 16'h4000 | 16'(i);
    reset = 1'b1; start = 1'b0; mode_run = 1'b0; step = 1'b0; branch_eq = 1'b0;
    model_reset();
    #12;
    chk("init_pc",      32'(pc),      32'd0);
    chk("init_commit",  32'(commit),  32'd0);
    chk("init_halted",  32'(halted),  32'd0);
    chk("init_busy",    32'(busy),    32'd0);
    chk("init_retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mon_on = 1'b1;

    // single-step: three steps spaced five cycles, start ignored while stepping
    cycle(1, 0, 0, 0);
    for (int j = 0; j < 15; j++) cycle(j == 2, 0, (j % 5) == 0, 0);
    chk("step_pc", 32'(pc), 32'd3);

    // step together with mode_run rising, then free run up to pc 9 and abort
    cycle(0, 1, 1, 0);
    guard = 0;
    while (m_pc != 9 && guard < 40) begin
      cycle(guard % 2 == 0, 1, 0, 0);
      guard++;
    end
    chk("pc_before_reset", 32'(pc), 32'd9);
    async_reset();

    // taken branch at 11 -> 19, halt at 20
    imem[11] = 16'b101_10011_0010_0101;
    imem[20] = 16'hFFFF;
    cycle(1, 1, 0, 0);
    for (int k = 0; k < 25; k++) cycle(k < 8 && (k % 3) == 0, 1, 0, 1);
    chk("halt_pc", 32'(pc), 32'd20);

    // restart, branch not taken: 11 -> 12 ... halt at 20
    cycle(1, 1, 0, 0);
    for (int k = 0; k < 25; k++) cycle(0, 1, 0, 0);

    // remove halt, run through the 31 -> 0 wrap, then drop to step mode
    imem[20] = 16'h4014;
    cycle(1, 1, 0, 0);
    for (int k = 0; k < 40; k++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cycle(1, 0, (k % 5) == 1, 1);

    // randomized program and control
    for (int i = 0; i < 32; i++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op == 7 && $urandom_range(0, 3) != 0) op = 2;
      imem[i] = {3'(op), 13'($urandom)};
    end
    rm = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) rm = ~rm;
      cycle($urandom_range(0, 7) == 0, rm, $urandom_range(0, 2) == 0, 1'($urandom));
    end

    cycle(0, 0, 0, 0);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter owner and execution sequencer for the single-cycle core. Drives the 5-bit read address of the 32x16 instruction memory, decodes opcode, branch target and halt from the returned word, and issues a one-cycle `commit` strobe that gates every architectural write (register file, data memory) in the datapath. Supports free-running and single-step execution, restart, and halt detection.

## Interface
- `IM_AW`, default 5: instruction memory address width (depth 2^IM_AW).
- `IW`, default 16: instruction width.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, no other clock domains.
- `start`  in  1  one-cycle pulse, begins or restarts execution.
- `mode_run`  in  1  1 = free run, 0 = single step.
- `step`  in  1  one-cycle pulse, executes one instruction in step mode.
- `branch_eq`  in  1  datapath comparator result for the current instruction, rA == rB.
- `instr`  in  IW  instruction word at `pc` (asynchronous memory read).
- `pc`  out  IM_AW  instruction memory read address.
- `commit`  out  1  current instruction executes this cycle; datapath writes are gated by it.
- `halted`  out  1  halt instruction reached.
- `busy`  out  1  state is RUN or STEP.
- `retired`  out  16  committed-instruction count (see Configuration).

## Operation
- Opcode is `instr[15:13]`. Halt is 3'b111; branch is 3'b101 with target `instr[12:8]`.
- States: IDLE, RUN, STEP, HALTED. Reset puts the block in IDLE.
- IDLE: `start` with `mode_run`=1 -> RUN; with `mode_run`=0 -> STEP. `pc` is held at 0.
- RUN: an instruction issues every cycle. `mode_run`=0 -> STEP; the current cycle still issues.
- STEP: an instruction issues only in a cycle with `step`=1. `mode_run`=1 -> RUN.
- HALTED: `start` -> `pc`=0, `retired` cleared, then RUN or STEP per `mode_run`.
- `start` is ignored in RUN and STEP. `step` is ignored outside STEP.
- Issue when the opcode is not halt:
  - `commit`=1.
  - Next `pc` = target if opcode is branch and `branch_eq`=1; otherwise `pc`+1 mod 32. After 31, `pc` wraps to 0.
- Issue when the opcode is halt:
  - `commit`=0 and `pc` unchanged.
  - Next state HALTED; the halt instruction is not counted.
- Simultaneous `step` and a `mode_run` 0->1 change in STEP: the step issues and the next state is RUN.

## Timing
- Reset values: `pc`=0, `commit`=0, `halted`=0, `busy`=0, `retired`=0, state IDLE.
- Reset mid-execution aborts immediately, with no commit in that cycle.
- `commit` is combinational from state, `step` and `instr`: (RUN | STEP&`step`) & opcode != 111. There is zero added latency to the datapath.
- `pc`, `halted`, `busy` and `retired` are registered and update on the rising edge that ends a commit cycle.
- `instr` and `branch_eq` must be stable within the same cycle, since memory read is asynchronous.
- Restart from HALTED or IDLE on `start`: the first commit occurs in the cycle after `start`.
- `halted` rises on the edge after the halt instruction is seen. It falls on the edge after `start`.

## Configuration
- Macro `FETCH_RETIRE_COUNT_EN`.
- Defined: `retired` counts commit cycles. It saturates at 16'hFFFF and clears on reset or restart.
- Undefined: the counter is not instantiated and `retired` is tied to 0.
- Control behaviour is identical with or without the macro.

## Structure
- The shared package `cpu_pkg` holds:
  - opcode constants `OP_STORE`=000, `OP_LOAD`=001, `OP_ADD`=010, `OP_BRANCH`=101, `OP_HALT`=111;
  - the `seq_state_t` enum {IDLE, RUN, STEP, HALTED};
  - `IM_AW` and `IW` defaults.
- One sub-module, `retire_counter`: a saturating 16-bit counter with `clk`, `reset`, `clear`, `inc`. It is instantiated only under `FETCH_RETIRE_COUNT_EN`.

## Test plan
- Reset then `start` with `mode_run`=1, sequential non-branch instructions at 0..3 -> `commit`=1 each cycle and `pc` reads 1, 2, 3, 4 on successive edges.
- Branch 16'b101_10011_0010_0101 at `pc`=11 with `branch_eq`=1 -> next `pc`=19. Same word with `branch_eq`=0 -> next `pc`=12.
- Step mode: `start` with `mode_run`=0, then 3 `step` pulses spaced 5 cycles apart -> exactly 3 commits, `pc`=3, and `retired`=3 when the macro is defined.
- Halt word 16'hFFFF at `pc`=20 in RUN:
  - `commit`=0 that cycle;
  - `halted`=1 next edge;
  - `pc` stays 20;
  - a later `start` gives `pc`=0 and `halted`=0.
- Wrap: non-branch at `pc`=31 -> next `pc`=0.
- Reset asserted asynchronously mid-RUN at `pc`=9 -> `pc`=0 and `busy`=0 immediately, with no commit. `start` pulsed during RUN has no effect.
